// File: rtl/led_pattern_driver_if.sv
// Mode-request handshake between the board controller and the LED pattern driver.
interface led_pattern_driver_if;
  logic [1:0] mode_req;
  logic       mode_valid;
  logic       mode_ready;

  modport master (output mode_req, output mode_valid, input mode_ready);
  modport slave  (input mode_req, input mode_valid, output mode_ready);
endinterface

// File: rtl/led_pattern_driver.sv
// Registered LED pattern engine: tick prescaler, free-running PWM, four display
// modes (count, scan, breathe, off), tick-aligned mode changes and a sticky
// error blink that overrides the displayed mode.
module led_pattern_driver #(
  parameter int     NUM_LEDS   = 9,
  parameter longint TICK_DIV   = 64'd8388608,
  parameter int     PWM_BITS   = 8,
  parameter int     ERR_HALF   = 8,
  parameter bit     ACTIVE_LOW = 1'b0
) (
  input  logic                       clk_u59,
  input  logic                       rst,
  led_pattern_driver_if.slave        mode_if,
  input  logic                       err_flag,
  output logic                       err_active,
  output logic [1:0]                 mode_cur,
  output logic [NUM_LEDS-1:0]        leds
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 64'd1);

  localparam int POS_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_NEAR_TOP = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ONE      = POS_W'(1);

  localparam logic [PWM_BITS-1:0] DUTY_MAX      = '1;
  localparam logic [PWM_BITS-1:0] DUTY_NEAR_TOP = DUTY_MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE      = PWM_BITS'(1);

  localparam int BLK_W = (ERR_HALF > 2) ? $clog2(ERR_HALF) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(ERR_HALF - 1);

  localparam logic [1:0] MODE_COUNT   = 2'd0;
  localparam logic [1:0] MODE_SCAN    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  localparam logic [NUM_LEDS-1:0] LED_IDLE = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_cur_q, mode_cur_d;
  logic [1:0]            next_mode_q, next_mode_d;
  logic                  blink_on_q, blink_on_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;

  logic [PRE_W-1:0]      prescale_q, prescale_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  duty_up_q, duty_up_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;

  logic                  tick;
  logic                  ready;
  logic                  accept;
  logic                  enter_err;
  logic [NUM_LEDS-1:0]   pattern;

  assign ready              = (state_q != ST_PEND);
  assign accept             = mode_if.mode_valid && ready;
  assign mode_if.mode_ready = ready;
  assign err_active         = (state_q == ST_ERROR);
  assign mode_cur           = mode_cur_q;
  assign leds               = leds_q;

  // Prescaler wraps at TICK_DIV-1 and the PWM counter free-runs every clock.
  always_comb begin
    tick       = (prescale_q == PRE_MAX);
    prescale_d = tick ? '0 : prescale_q + PRE_W'(1);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
  end

  // Pattern state advances on every tick whatever mode is on display; the
  // scan position and duty bounce between their ends, showing each end once.
  always_comb begin
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    dir_up_d  = dir_up_q;
    duty_d    = duty_q;
    duty_up_d = duty_up_q;
    if (tick) begin
      cnt_d = cnt_q + NUM_LEDS'(1);
      if (dir_up_q) begin
        pos_d = pos_q + POS_ONE;
        if (pos_q == POS_NEAR_TOP) dir_up_d = 1'b0;
      end else begin
        pos_d = pos_q - POS_ONE;
        if (pos_q == POS_ONE) dir_up_d = 1'b1;
      end
      if (duty_up_q) begin
        duty_d = duty_q + DUTY_ONE;
        if (duty_q == DUTY_NEAR_TOP) duty_up_d = 1'b0;
      end else begin
        duty_d = duty_q - DUTY_ONE;
        if (duty_q == DUTY_ONE) duty_up_d = 1'b1;
      end
    end
  end

  // Control FSM: errors win over accepts and ticks, mode changes land on the
  // next tick, and the blink phase restarts lit whenever the error is entered.
  always_comb begin
    state_d     = state_q;
    mode_cur_d  = mode_cur_q;
    next_mode_d = next_mode_q;
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    enter_err   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (err_flag) begin
          state_d   = ST_ERROR;
          enter_err = 1'b1;
        end else if (accept) begin
          next_mode_d = mode_if.mode_req;
          state_d     = ST_PEND;
        end
      end
      ST_PEND: begin
        if (err_flag) begin
          state_d   = ST_ERROR;
          enter_err = 1'b1;
        end else if (tick) begin
          mode_cur_d = next_mode_q;
          state_d    = ST_RUN;
        end
      end
      ST_ERROR: begin
        if (accept) begin
          next_mode_d = mode_if.mode_req;
          if (!err_flag) state_d = ST_PEND;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (enter_err) begin
      blink_on_d  = 1'b1;
      blink_cnt_d = '0;
    end else if (state_q == ST_ERROR && tick) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // LED image built from this cycle's state; polarity is applied here so the
  // output register holds the final pin level.
  always_comb begin
    pattern = '0;
    if (state_q == ST_ERROR) begin
      pattern = blink_on_q ? '1 : '0;
    end else begin
      case (mode_cur_q)
        MODE_COUNT:   pattern = cnt_q;
        MODE_SCAN:    pattern = NUM_LEDS'(1) << pos_q;
        MODE_BREATHE: pattern = {NUM_LEDS{pwm_cnt_q < duty_q}};
        MODE_OFF:     pattern = '0;
        default:      pattern = '0;
      endcase
    end
    leds_d = pattern ^ LED_IDLE;
  end

  // Control state, mode registers and blink phase.
  always_ff @(posedge clk_u59 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mode_cur_q  <= MODE_COUNT;
      next_mode_q <= MODE_COUNT;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_cur_q  <= mode_cur_d;
      next_mode_q <= next_mode_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Prescaler, PWM counter, pattern state and the LED output register.
  always_ff @(posedge clk_u59 or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      pwm_cnt_q  <= '0;
      cnt_q      <= '0;
      pos_q      <= '0;
      dir_up_q   <= 1'b1;
      duty_q     <= '0;
      duty_up_q  <= 1'b1;
      leds_q     <= LED_IDLE;
    end else begin
      prescale_q <= prescale_d;
      pwm_cnt_q  <= pwm_cnt_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      dir_up_q   <= dir_up_d;
      duty_q     <= duty_d;
      duty_up_q  <= duty_up_d;
      leds_q     <= leds_d;
    end
  end

endmodule

// File: doc/led_pattern_driver.md
# led_pattern_driver

Downstream LED output stage for the board top level. It replaces the raw counter-to-LED assignment with a registered pattern engine that drives the nine front-panel LEDs from a tick prescaler. Four display modes are available: binary count, scanning dot, PWM breathe, and off. A sticky error blink overrides whichever mode is active. Mode changes are requested through a valid/ready handshake and take effect only on tick boundaries, so patterns never glitch mid-step.

## Interface

Parameters:
- NUM_LEDS, 9, number of LED outputs.
- TICK_DIV, 8388608, clocks per pattern tick. Legal range is 2 to 2^32.
- PWM_BITS, 8, width of the PWM counter and the breathe duty.
- ERR_HALF, 8, ticks per half-period of the error blink.
- ACTIVE_LOW, 0. When set to 1, every leds bit is inverted at the output register.

Ports:
- clk_u59, in, 1: sole clock. Every register is on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- mode_req, in, 2: requested mode. 0=COUNT, 1=SCAN, 2=BREATHE, 3=OFF.
- mode_valid, in, 1: request strobe. Must hold with a stable mode_req until accepted.
- mode_ready, out, 1: the block can accept a request this cycle.
- err_flag, in, 1: error level, sampled every cycle.
- err_active, out, 1: the error override is latched.
- mode_cur, out, 2: mode currently being displayed.
- leds, out, NUM_LEDS: registered LED drive.

## Operation

Prescaler:
- prescale counts 0 to TICK_DIV-1 and then wraps to 0.
- tick is high for exactly one cycle, when prescale == TICK_DIV-1.

PWM:
- pwm_cnt is a free-running PWM_BITS counter, incremented every clock, wrapping naturally.
- A LED is lit in BREATHE when pwm_cnt < duty.
- duty=0 means always off. duty=2^PWM_BITS-1 means lit for 255 of 256 cycles.

Pattern state, updated on tick only:
- COUNT: cnt (NUM_LEDS wide) increments by 1 and wraps from all-ones to 0. leds = cnt.
- SCAN: pos runs from 0 up to NUM_LEDS-1, then back down to 0.
  - dir flips on the tick that lands on an end, so each end is displayed for exactly one tick.
  - leds = one-hot(pos).
- BREATHE: duty steps by 1 per tick, from 0 up to max and then back down to 0.
  - The endpoint values are held for one tick, as in SCAN.
  - All LEDs share the same duty.
- OFF: leds = 0.
- cnt, pos/dir and duty advance every tick regardless of the displayed mode. They are never reset by a mode change.

Control FSM:
- States are RUN, PEND and ERROR.
- RUN: mode_ready=1.
  - On mode_valid && mode_ready, latch mode_req into next_mode and go to PEND.
- PEND: mode_ready=0.
  - On tick, mode_cur <= next_mode and go to RUN.
- ERROR: mode_ready=1 and err_active=1.
  - leds are all-ones for ERR_HALF ticks, then all-zeros for ERR_HALF ticks, repeating. The phase starts all-ones on entry.
  - An accept while err_flag=0 latches next_mode, clears err_active and goes to PEND.
  - An accept while err_flag=1 still updates next_mode, but the state stays ERROR.
- err_flag=1 in any cycle while in RUN or PEND forces ERROR on the next edge.
  - The error has priority over a simultaneous accept or tick.
  - A pending next_mode is discarded.

Output:
- leds is registered from the state of the previous cycle. ACTIVE_LOW inversion is applied at that register.

## Timing

Reset values (asynchronous):
- State = RUN and mode_cur = 0 (COUNT).
- mode_ready = 1 and err_active = 0.
- prescale, pwm_cnt, cnt, pos and duty = 0. dir = up. Blink phase = on.
- leds = 0, or all-ones when ACTIVE_LOW=1.

Latencies:
- Accept to mode_cur change: from 1 up to TICK_DIV cycles after the accept edge, landing on the first tick strictly after the accept.
- Pattern state change to leds: 1 cycle.
- err_flag rising to err_active=1: 1 cycle. The blink appears on leds 1 cycle after that.
- When accept and tick coincide in RUN, the mode waits for the next tick.

Handshake rules:
- An accept is defined as a cycle with mode_valid && mode_ready.
- mode_ready drops on the edge after an accept. At most one request is accepted per PEND period.

Asserting reset mid-operation (PEND, ERROR or mid-blink) returns every register to its reset value immediately.

## Test plan

All scenarios use TICK_DIV=4 and ERR_HALF=2.
- Reset then run COUNT: release rst and run 40 cycles -> a tick every 4 cycles and leds=1,2,3… Leds 9'h1FF is followed by 9'h000 after wrap.
- Mode change to SCAN: request mode 1 at cycle 1 after a tick -> mode_ready=0 for 3 cycles and mode_cur=1 at the next tick. leds walk 001,002,…,100 and back, with 9'h100 shown for exactly one tick.
- Tick coincident with accept: assert mode_valid on the cycle tick is high -> mode_cur changes 4 cycles later, not in the same cycle.
- BREATHE: set mode 2 and let duty reach 3 -> leds are high exactly 3 of every 256 cycles, and duty reverses at 255.
- Error override: pulse err_flag for 1 cycle in PEND -> err_active=1 next cycle and the pending mode is dropped. leds run 1FF for 8 cycles, then 000 for 8 cycles. A request for mode 3 with err_flag=0 exits to OFF at the next tick.
- Async reset mid-ERROR: assert rst off-edge -> leds=0, err_active=0, mode_ready=1 and mode_cur=0 without waiting for a clock.
